i2c_slave_rx_tx: RTL



---
 rtl/i2c_slave_rx_tx.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_rx_tx.sv
// I2C target endpoint: oversampled scl/sda, 7-bit address match, byte receive
// to a local strobe interface and byte transmit from a local load interface.
`timescale 1ns/1ps
module i2c_slave_rx_tx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h77,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_match,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX       = 3'd3,
    RX_ACK   = 3'd4,
    TX       = 3'd5,
    TX_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_dly_q, sda_dly_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic       done_q, match_q, rw_q;
  logic [6:0] shift_q;
  logic [7:0] tx_shift_q;
  logic       sda_low_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q, tx_load_q, addr_match_q, busy_q;

  // Synchroniser chains follow the pins continuously so reset never fakes a bus edge
  always_ff @(posedge clk) begin
    scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
    sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_dly_q;
  assign scl_fall  = ~scl_s & scl_dly_q;
  // scl must be high in both samples, so a coincident scl edge counts as data
  assign start_det = scl_s & scl_dly_q & ~sda_s & sda_dly_q;
  assign stop_det  = scl_s & scl_dly_q & sda_s & ~sda_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      done_q       <= 1'b0;
      match_q      <= 1'b0;
      rw_q         <= 1'b0;
      sda_low_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      tx_load_q    <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      if (start_det) begin
        state_q      <= ADDR;
        bit_cnt_q    <= '0;
        done_q       <= 1'b0;
        sda_low_q    <= 1'b0;
        busy_q       <= 1'b1;
        addr_match_q <= 1'b0;
      end else if (stop_det) begin
        state_q      <= IDLE;
        bit_cnt_q    <= '0;
        done_q       <= 1'b0;
        sda_low_q    <= 1'b0;
        busy_q       <= 1'b0;
        addr_match_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[5:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                done_q  <= 1'b1;
                match_q <= (shift_q == SLAVE_ADDR);
                rw_q    <= sda_s;
              end
            end else if (scl_fall && done_q) begin
              done_q <= 1'b0;
              if (match_q) begin
                sda_low_q    <= 1'b1;
                addr_match_q <= 1'b1;
                state_q      <= ADDR_ACK;
                if (rw_q) begin
                  tx_load_q  <= 1'b1;
                  tx_shift_q <= tx_data;
                end
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= '0;
              if (rw_q) begin
                sda_low_q  <= ~tx_shift_q[7];
                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                state_q    <= TX;
              end else begin
                sda_low_q <= 1'b0;
                state_q   <= RX;
              end
            end
          end
          RX: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[5:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                done_q     <= 1'b1;
                rx_data_q  <= {shift_q, sda_s};
                rx_valid_q <= 1'b1;
              end
            end else if (scl_fall && done_q) begin
              done_q    <= 1'b0;
              sda_low_q <= 1'b1;
              state_q   <= RX_ACK;
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              sda_low_q <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= RX;
            end
          end
          TX: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) done_q <= 1'b1;
            end else if (scl_fall) begin
              if (done_q) begin
                done_q    <= 1'b0;
                sda_low_q <= 1'b0;
                state_q   <= TX_ACK;
              end else begin
                sda_low_q  <= ~tx_shift_q[7];
                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
              end
            end
          end
          TX_ACK: begin
            // Master ACK reloads the shifter; NACK ends our part of the read
            if (scl_rise) begin
              if (!sda_s) begin
                tx_load_q  <= 1'b1;
                tx_shift_q <= tx_data;
              end else begin
                state_q <= IGNORE;
              end
            end else if (scl_fall) begin
              sda_low_q  <= ~tx_shift_q[7];
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
              bit_cnt_q  <= '0;
              state_q    <= TX;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda        = sda_low_q ? 1'b0 : 1'bz;
  assign tx_load    = tx_load_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign addr_match = addr_match_q;
  assign busy       = busy_q;
  assign state      = state_q;

endmodule
